// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32I pipeline registers: default widths,
// write-back source encodings and the control values that make up a bubble.
package pipe_pkg;

    localparam int unsigned XLEN_DEF   = 32;
    localparam int unsigned REG_AW_DEF = 5;
    localparam int unsigned RSRC_W_DEF = 2;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        RSRC_ALU = 2'd0,
        RSRC_MEM = 2'd1,
        RSRC_PC4 = 2'd2
    } rsrc_e;

    // A bubble never writes anything and selects the ALU path.
    localparam int unsigned BUBBLE_RD        = 0;
    localparam logic        BUBBLE_VALID     = 1'b0;
    localparam logic        BUBBLE_REG_WRITE = 1'b0;
    localparam logic        BUBBLE_MEM_WRITE = 1'b0;

endpackage

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register: synchronous reset, synchronous clear to a
// fixed bubble value, and hold. Priority is reset > clear > hold > load.
module pipe_field_reg #(
    parameter int unsigned       WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0,
    parameter logic [WIDTH-1:0]  CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             hold,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    // Field storage with reset/clear/hold/load priority
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= RST_VAL;
        end else if (clr) begin
            q_r <= CLR_VAL;
        end else if (hold) begin
            q_r <= q_r;
        end else begin
            q_r <= d;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with stall/flush, valid-gated side-effect
// controls, EX-stage forwarding match flags and a saturating stall counter.
module ex_mem_pipe_reg
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter int unsigned RSRC_W = RSRC_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              stall_m,
    input  logic              flush_m,
    input  logic              valid_e,
    input  logic [XLEN-1:0]   alu_result_e,
    input  logic [XLEN-1:0]   write_data_e,
    input  logic [XLEN-1:0]   pc_plus4_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic              reg_write_e,
    input  logic              mem_write_e,
    input  logic [RSRC_W-1:0] result_src_e,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    output logic [XLEN-1:0]   alu_result_m,
    output logic [XLEN-1:0]   write_data_m,
    output logic [XLEN-1:0]   pc_plus4_m,
    output logic [REG_AW-1:0] rd_m,
    output logic              reg_write_m,
    output logic              mem_write_m,
    output logic [RSRC_W-1:0] result_src_m,
    output logic              valid_m,
    output logic              fwd_a_hit,
    output logic              fwd_b_hit,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned       DATA_W      = 3 * XLEN;
    localparam int unsigned       CTRL_W      = RSRC_W + 2;
    localparam logic [REG_AW-1:0] RD_BUBBLE   = REG_AW'(BUBBLE_RD);
    localparam logic [RSRC_W-1:0] RSRC_BUBBLE = RSRC_W'(RSRC_ALU);
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = {BUBBLE_REG_WRITE, BUBBLE_MEM_WRITE, RSRC_BUBBLE};
    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

    logic [DATA_W-1:0] data_d_s;
    logic [DATA_W-1:0] data_q_s;
    logic [CTRL_W-1:0] ctrl_d_s;
    logic [CTRL_W-1:0] ctrl_q_s;
    logic [REG_AW-1:0] rd_q_s;
    logic              valid_q_s;
    logic              fwd_a_hit_s;
    logic              fwd_b_hit_s;
    logic              stall_only_s;
    logic [CNT_W-1:0]  stall_cnt_r;

    assign data_d_s = {alu_result_e, write_data_e, pc_plus4_e};
    // Side-effecting controls are qualified by valid before they are captured.
    assign ctrl_d_s = {reg_write_e & valid_e, mem_write_e & valid_e, result_src_e};

    pipe_field_reg #(
        .WIDTH   (DATA_W),
        .RST_VAL ({DATA_W{1'b0}}),
        .CLR_VAL ({DATA_W{1'b0}})
    ) u_data_reg (
        .clk  (Clk),
        .rst  (Reset),
        .clr  (flush_m),
        .hold (stall_m),
        .d    (data_d_s),
        .q    (data_q_s)
    );

    pipe_field_reg #(
        .WIDTH   (REG_AW),
        .RST_VAL ({REG_AW{1'b0}}),
        .CLR_VAL (RD_BUBBLE)
    ) u_rd_reg (
        .clk  (Clk),
        .rst  (Reset),
        .clr  (flush_m),
        .hold (stall_m),
        .d    (rd_e),
        .q    (rd_q_s)
    );

    pipe_field_reg #(
        .WIDTH   (CTRL_W),
        .RST_VAL (CTRL_BUBBLE),
        .CLR_VAL (CTRL_BUBBLE)
    ) u_ctrl_reg (
        .clk  (Clk),
        .rst  (Reset),
        .clr  (flush_m),
        .hold (stall_m),
        .d    (ctrl_d_s),
        .q    (ctrl_q_s)
    );

    pipe_field_reg #(
        .WIDTH   (1),
        .RST_VAL (BUBBLE_VALID),
        .CLR_VAL (BUBBLE_VALID)
    ) u_valid_reg (
        .clk  (Clk),
        .rst  (Reset),
        .clr  (flush_m),
        .hold (stall_m),
        .d    (valid_e),
        .q    (valid_q_s)
    );

    // A flush wins over a simultaneous stall, so that cycle is not counted.
    assign stall_only_s = stall_m & ~flush_m;

    // Saturating stall-cycle counter, cleared only by reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_only_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Forwarding match against the MEM-stage destination; x0 never forwards
    always_comb begin
        fwd_a_hit_s = 1'b0;
        fwd_b_hit_s = 1'b0;
        if (valid_q_s && ctrl_q_s[CTRL_W-1] && (rd_q_s != {REG_AW{1'b0}})) begin
            fwd_a_hit_s = (rd_q_s == rs1_e);
            fwd_b_hit_s = (rd_q_s == rs2_e);
        end else begin
            fwd_a_hit_s = 1'b0;
            fwd_b_hit_s = 1'b0;
        end
    end

    assign alu_result_m = data_q_s[DATA_W-1 -: XLEN];
    assign write_data_m = data_q_s[2*XLEN-1 -: XLEN];
    assign pc_plus4_m   = data_q_s[XLEN-1:0];
    assign rd_m         = rd_q_s;
    assign reg_write_m  = ctrl_q_s[CTRL_W-1];
    assign mem_write_m  = ctrl_q_s[CTRL_W-2];
    assign result_src_m = ctrl_q_s[RSRC_W-1:0];
    assign valid_m      = valid_q_s;
    assign fwd_a_hit    = fwd_a_hit_s;
    assign fwd_b_hit    = fwd_b_hit_s;
    assign stall_cnt    = stall_cnt_r;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Self-checking bench for ex_mem_pipe_reg: directed cases plus randomized
// traffic compared every cycle against a behavioural model of the stage.
module tb_ex_mem_pipe_reg;

    logic        Clk = 1'b0;
    logic        Reset, stall_m, flush_m, valid_e;
    logic [31:0] alu_result_e, write_data_e, pc_plus4_e;
    logic [4:0]  rd_e, rs1_e, rs2_e;
    logic        reg_write_e, mem_write_e;
    logic [1:0]  result_src_e;

    logic [31:0] alu_result_m, write_data_m, pc_plus4_m;
    logic [4:0]  rd_m;
    logic        reg_write_m, mem_write_m, valid_m, fwd_a_hit, fwd_b_hit;
    logic [1:0]  result_src_m;
    logic [15:0] stall_cnt;

    logic [31:0] alu_result_m3, write_data_m3, pc_plus4_m3;
    logic [4:0]  rd_m3;
    logic        reg_write_m3, mem_write_m3, valid_m3, fwd_a_hit3, fwd_b_hit3;
    logic [1:0]  result_src_m3;
    logic [2:0]  stall_cnt3;

    int n_vec = 0;
    int n_err = 0;

    // model state: what the MEM stage must hold
    logic        m_valid, m_rw, m_mw, m_data_ok;
    logic [1:0]  m_rsrc;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_wd, m_pc;
    int          m_cnt, m_cnt3;

    always #5 Clk = ~Clk;

    ex_mem_pipe_reg u_dut (
        .Clk(Clk), .Reset(Reset), .stall_m(stall_m), .flush_m(flush_m), .valid_e(valid_e),
        .alu_result_e(alu_result_e), .write_data_e(write_data_e), .pc_plus4_e(pc_plus4_e),
        .rd_e(rd_e), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
        .result_src_e(result_src_e), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .alu_result_m(alu_result_m), .write_data_m(write_data_m), .pc_plus4_m(pc_plus4_m),
        .rd_m(rd_m), .reg_write_m(reg_write_m), .mem_write_m(mem_write_m),
        .result_src_m(result_src_m), .valid_m(valid_m), .fwd_a_hit(fwd_a_hit),
        .fwd_b_hit(fwd_b_hit), .stall_cnt(stall_cnt)
    );

    ex_mem_pipe_reg #(.CNT_W(3)) u_dut3 (
        .Clk(Clk), .Reset(Reset), .stall_m(stall_m), .flush_m(flush_m), .valid_e(valid_e),
        .alu_result_e(alu_result_e), .write_data_e(write_data_e), .pc_plus4_e(pc_plus4_e),
        .rd_e(rd_e), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
        .result_src_e(result_src_e), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .alu_result_m(alu_result_m3), .write_data_m(write_data_m3), .pc_plus4_m(pc_plus4_m3),
        .rd_m(rd_m3), .reg_write_m(reg_write_m3), .mem_write_m(mem_write_m3),
        .result_src_m(result_src_m3), .valid_m(valid_m3), .fwd_a_hit(fwd_a_hit3),
        .fwd_b_hit(fwd_b_hit3), .stall_cnt(stall_cnt3)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Random inputs for one cycle; rs inputs often aim at the current MEM rd.
    task automatic drive(input bit r, input bit s, input bit f);
        Reset        = r;
        stall_m      = s;
        flush_m      = f;
        valid_e      = ($urandom_range(0, 3) != 0);
        alu_result_e = $urandom;
        write_data_e = $urandom;
        pc_plus4_e   = $urandom;
        rd_e         = 5'($urandom_range(0, 31));
        reg_write_e  = 1'($urandom);
        mem_write_e  = 1'($urandom);
        result_src_e = 2'($urandom_range(0, 2));
        rs1_e        = ($urandom_range(0, 2) == 0) ? m_rd : 5'($urandom_range(0, 31));
        rs2_e        = ($urandom_range(0, 2) == 0) ? m_rd : 5'($urandom_range(0, 31));
    endtask

    task automatic model_update();
        if (Reset) begin
            m_valid = 1'b0; m_rw = 1'b0; m_mw = 1'b0; m_rsrc = 2'd0; m_rd = 5'd0;
            m_alu = 32'd0; m_wd = 32'd0; m_pc = 32'd0; m_data_ok = 1'b1;
            m_cnt = 0; m_cnt3 = 0;
        end else if (flush_m) begin
            m_valid = 1'b0; m_rw = 1'b0; m_mw = 1'b0; m_rsrc = 2'd0; m_rd = 5'd0;
            m_data_ok = 1'b0;
        end else if (stall_m) begin
            m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
            m_cnt3 = (m_cnt3 < 7)     ? m_cnt3 + 1 : m_cnt3;
        end else begin
            m_valid = valid_e;
            m_rw    = reg_write_e && valid_e;
            m_mw    = mem_write_e && valid_e;
            m_rsrc  = result_src_e;
            m_rd    = rd_e;
            m_alu   = alu_result_e;
            m_wd    = write_data_e;
            m_pc    = pc_plus4_e;
            m_data_ok = 1'b1;
        end
    endtask

    task automatic check_all();
        logic exp_a, exp_b;
        exp_a = m_valid && m_rw && (m_rd != 5'd0) && (m_rd == rs1_e);
        exp_b = m_valid && m_rw && (m_rd != 5'd0) && (m_rd == rs2_e);
        chk("valid_m", 64'(valid_m), 64'(m_valid));
        chk("reg_write_m", 64'(reg_write_m), 64'(m_rw));
        chk("mem_write_m", 64'(mem_write_m), 64'(m_mw));
        chk("result_src_m", 64'(result_src_m), 64'(m_rsrc));
        chk("rd_m", 64'(rd_m), 64'(m_rd));
        if (m_data_ok) begin
            chk("alu_result_m", 64'(alu_result_m), 64'(m_alu));
            chk("write_data_m", 64'(write_data_m), 64'(m_wd));
            chk("pc_plus4_m", 64'(pc_plus4_m), 64'(m_pc));
        end
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        chk("stall_cnt3", 64'(stall_cnt3), 64'(m_cnt3));
        chk("fwd_a_hit", 64'(fwd_a_hit), 64'(exp_a));
        chk("fwd_b_hit", 64'(fwd_b_hit), 64'(exp_b));
    endtask

    // Inputs are stable from the previous negedge; model advances at the edge.
    task automatic tick();
        @(posedge Clk);
        model_update();
        @(negedge Clk);
        check_all();
    endtask

    initial begin
        m_rd = 5'd0;
        @(negedge Clk);

        // reset with every input at 1s
        Reset = 1'b1; stall_m = 1'b1; flush_m = 1'b1; valid_e = 1'b1;
        alu_result_e = '1; write_data_e = '1; pc_plus4_e = '1; rd_e = '1;
        reg_write_e = 1'b1; mem_write_e = 1'b1; result_src_e = '1; rs1_e = '1; rs2_e = '1;
        tick();
        chk("rst_alu_lit", 64'(alu_result_m), 64'd0);
        chk("rst_valid_lit", 64'(valid_m), 64'd0);
        chk("rst_cnt_lit", 64'(stall_cnt), 64'd0);

        // directed load, rd = 31 keeps bit 4
        drive(1'b0, 1'b0, 1'b0);
        alu_result_e = 32'h1000_0004; write_data_e = 32'hDEAD_BEEF; pc_plus4_e = 32'h0000_0010;
        rd_e = 5'd31; reg_write_e = 1'b1; mem_write_e = 1'b0; valid_e = 1'b1; result_src_e = 2'd0;
        tick();
        chk("load_alu_lit", 64'(alu_result_m), 64'h1000_0004);
        chk("load_wd_lit", 64'(write_data_m), 64'hDEAD_BEEF);
        chk("load_rd_lit", 64'(rd_m), 64'd31);

        // three stalled cycles with changing inputs
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            tick();
            chk("stall_hold_lit", 64'(alu_result_m), 64'h1000_0004);
        end
        chk("stall3_cnt_lit", 64'(stall_cnt), 64'd3);

        // stall and flush together: bubble, no count
        drive(1'b0, 1'b1, 1'b1);
        valid_e = 1'b1; reg_write_e = 1'b1; mem_write_e = 1'b1;
        tick();
        chk("flush_valid_lit", 64'(valid_m), 64'd0);
        chk("flush_mw_lit", 64'(mem_write_m), 64'd0);
        chk("flush_cnt_lit", 64'(stall_cnt), 64'd3);

        // forwarding hit on rd 5, then x0 never forwards
        drive(1'b0, 1'b0, 1'b0);
        rd_e = 5'd5; reg_write_e = 1'b1; valid_e = 1'b1; rs1_e = 5'd5; rs2_e = 5'd6;
        tick();
        chk("fwd_a_lit", 64'(fwd_a_hit), 64'd1);
        chk("fwd_b_lit", 64'(fwd_b_hit), 64'd0);
        drive(1'b0, 1'b0, 1'b0);
        rd_e = 5'd0; reg_write_e = 1'b1; valid_e = 1'b1; rs1_e = 5'd0;
        tick();
        chk("fwd_x0_lit", 64'(fwd_a_hit), 64'd0);

        // ten stalls: 3-bit counter saturates at 7
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            tick();
        end
        chk("sat_cnt3_lit", 64'(stall_cnt3), 64'd7);
        chk("sat_cnt16_lit", 64'(stall_cnt), 64'd13);

        // reset mid-stall
        drive(1'b1, 1'b1, 1'b0);
        tick();
        chk("rst_cnt3_lit", 64'(stall_cnt3), 64'd0);

        // back-to-back flushes, then a normal load
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
        valid_e = 1'b1; rd_e = 5'd9;
        tick();
        chk("post_flush_rd_lit", 64'(rd_m), 64'd9);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
